// File: rtl/hamming_pkg.sv
// Shared types and constants for the serial Hamming similarity/distance unit.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic MOD_BENZERLIK = 1'b0;
    localparam logic MOD_MESAFE    = 1'b1;

endpackage

// File: rtl/hamming_parca.sv
// Combinational popcount of one C-bit chunk.
module hamming_parca #(
    parameter int C  = 4,
    parameter int PW = $clog2(C + 1)
) (
    input  logic [C-1:0]  chunk,
    output logic [PW-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < C; i++) begin
            cnt = cnt + PW'(chunk[i]);
        end
    end

endmodule

// File: rtl/hamming_benzer_seri.sv
// Serial Hamming similarity/distance unit, C bits per cycle, LSB chunk first.
// Optional threshold compare (esik/esik_gecti) enabled by HAMMING_ESIK_EN.
module hamming_benzer_seri
    import hamming_pkg::*;
#(
    parameter int W = 16,
    parameter int C = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              A,
    input  logic [W-1:0]              B,
    input  logic                      mode,
`ifdef HAMMING_ESIK_EN
    input  logic [$clog2(W+1)-1:0]    esik,
    output logic                      esik_gecti,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(W+1)-1:0]    HB
);

    localparam int N  = W / C;
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(C + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if ((C < 1) || (C > W) || ((W % C) != 0)) begin : g_param_chk
        $error("hamming_benzer_seri: W must be a multiple of C and 1 <= C <= W");
    end

    state_t          state_q, state_d;
    logic [W-1:0]    vec_q;
    logic [CW-1:0]   acc_q;
    logic [KW-1:0]   k_q;
    logic [CW-1:0]   hb_q;
    logic [C-1:0]    chunk;
    logic [PW-1:0]   cnt;
    logic [CW-1:0]   sum;
    logic            last;

    // XOR/XNOR is folded in at accept, so only the bit vector to count is kept.
    assign chunk = vec_q[k_q * C +: C];
    assign sum   = acc_q + CW'(cnt);
    assign last  = (k_q == KW'(N - 1));

    hamming_parca #(.C(C), .PW(PW)) u_parca (
        .chunk (chunk),
        .cnt   (cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef HAMMING_ESIK_EN
    logic [CW-1:0] esik_q;
    logic          gecti_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            esik_q  <= '0;
            gecti_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            esik_q <= esik;
        end else if (state_q == BUSY && last) begin
            gecti_q <= (sum >= esik_q);
        end
    end

    assign esik_gecti = gecti_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            hb_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        vec_q <= (mode == MOD_MESAFE) ? (A ^ B) : ~(A ^ B);
                        acc_q <= '0;
                        k_q   <= '0;
                    end
                end
                BUSY: begin
                    if (last) begin
                        hb_q <= sum;
                    end else begin
                        acc_q <= sum;
                        k_q   <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign HB        = hb_q;

endmodule

// File: tb/tb_hamming_benzer_seri.sv
// Directed self-checking bench for hamming_benzer_seri (W=16,C=4 and W=C=8).
module tb_hamming_benzer_seri;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, mode;
    logic [15:0] A, B;
    logic        in_ready, out_valid;
    logic [4:0]  HB;

    logic        in_valid8, out_ready8, mode8;
    logic [7:0]  A8, B8;
    logic        in_ready8, out_valid8;
    logic [3:0]  HB8;

`ifdef HAMMING_ESIK_EN
    logic [4:0]  esik;
    logic        esik_gecti;
    logic        esik_gecti8;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hamming_benzer_seri #(.W(16), .C(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .mode       (mode),
`ifdef HAMMING_ESIK_EN
        .esik       (esik),
        .esik_gecti (esik_gecti),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .HB         (HB)
    );

    hamming_benzer_seri #(.W(8), .C(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .A          (A8),
        .B          (B8),
        .mode       (mode8),
`ifdef HAMMING_ESIK_EN
        .esik       (4'd0),
        .esik_gecti (esik_gecti8),
`endif
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .HB         (HB8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one operation on the 16-bit DUT, leave it in DONE with out_ready=0.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                         output logic [4:0] hb_o, output int lat);
        @(negedge clk);
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        A = a; B = b; mode = m; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        hb_o = HB;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [4:0] r;
    int         lat;
    int         acc_t [$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; A = '0; B = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = 1'b0; A8 = '0; B8 = '0;
`ifdef HAMMING_ESIK_EN
        esik = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hb", 32'(HB), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op(16'hFFFF, 16'hFFFF, 1'b0, r, lat);
        chk("ffff_sim_hb", 32'(r), 32'd16);
        chk("ffff_sim_latency", 32'(lat), 32'd4);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        consume();
        chk("consumed_out_valid", 32'(out_valid), 32'd0);

        do_op(16'hFFFF, 16'hFFFF, 1'b1, r, lat);
        chk("ffff_dist_hb", 32'(r), 32'd0);
        consume();
        do_op(16'hA5A5, 16'h5A5A, 1'b0, r, lat);
        chk("a5_sim_hb", 32'(r), 32'd0);
        consume();
        do_op(16'hA5A5, 16'h5A5A, 1'b1, r, lat);
        chk("a5_dist_hb", 32'(r), 32'd16);
        consume();
        do_op(16'h00F0, 16'h0000, 1'b1, r, lat);
        chk("f0_dist_hb", 32'(r), 32'd4);
        consume();

`ifdef HAMMING_ESIK_EN
        esik = 5'd13;
        do_op(16'h00F0, 16'h0000, 1'b0, r, lat);
        chk("esik13_gecti", 32'(esik_gecti), 32'd0);
        consume();
        esik = 5'd12;
`endif

        // Stall in DONE while the input side keeps trying to push new work.
        do_op(16'h00F0, 16'h0000, 1'b0, r, lat);
        chk("f0_sim_hb", 32'(r), 32'd12);
`ifdef HAMMING_ESIK_EN
        chk("esik12_gecti", 32'(esik_gecti), 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = 16'(i * 16'h1357); B = ~A; mode = i[0];
            @(posedge clk); #1;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hb", 32'(HB), 32'd12);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release_out_valid", 32'(out_valid), 32'd0);
        chk("stall_release_in_ready", 32'(in_ready), 32'd1);
        chk("stall_release_hb", 32'(HB), 32'd12);

        // Back-to-back: handshakes held high, record the cycles of accepts.
        A = 16'h1234; B = 16'h4321; mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (in_ready) acc_t.push_back(cyc);
        end
        in_valid = 1'b0;
        chk("b2b_accept_count", 32'(acc_t.size() >= 3), 32'd1);
        if (acc_t.size() >= 3) begin
            chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd6);
            chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd6);
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_drain_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_hb", 32'(HB), 32'd6);

        // Reset after chunk 2 of an in-flight operation.
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_hb", 32'(HB), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_out_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'hA5A5, 16'h5A5A, 1'b1, r, lat);
        chk("after_rst_hb", 32'(r), 32'd16);
        consume();

        // W=C=8: single BUSY cycle.
        @(negedge clk);
        chk("w8_in_ready", 32'(in_ready8), 32'd1);
        A8 = 8'h07; B8 = 8'h00; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_latency", 32'(lat), 32'd1);
        chk("w8_hb", 32'(HB8), 32'd5);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("w8_consumed", 32'(out_valid8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_benzer_seri.md
# hamming_benzer_seri

Parametrised, sequential Hamming similarity/distance unit. It accepts two W-bit operands over a valid/ready handshake and processes them C bits per clock, least-significant chunk first. It accumulates the per-chunk match or mismatch count and returns the total over a second valid/ready handshake. It replaces the fixed 4-bit combinational similarity counter wherever wide operands make a single-cycle popcount too slow or too large.

## Interface
- W, 16: operand width in bits; must be a multiple of C.
- C, 4: bits processed per cycle; 1 ≤ C ≤ W.
- N (localparam), W/C: number of chunks, equal to the BUSY cycle count.
- CW (localparam), $clog2(W+1): result width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE while rst_n=1.
- A  in  W  operand A; sampled on accept.
- B  in  W  operand B; sampled on accept.
- mode  in  1  sampled on accept. 0 = similarity (count of XNOR ones); 1 = distance (count of XOR ones).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  result consumed.
- HB  out  CW  result count; held stable while out_valid=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch A, B and mode;
  - clear the accumulator and chunk index k to 0;
  - go to BUSY.
- BUSY: each edge adds popcount(chunk k) to the accumulator and increments k.
  - chunk k is bits [k*C+C-1 : k*C] of (A XNOR B) for mode 0, or of (A XOR B) for mode 1;
  - on the edge that processes k=N-1, the final sum is written to HB and the state goes to DONE.
- DONE: out_valid=1. On out_ready=1 the state goes to IDLE. HB keeps its value until the next result is written.
- in_valid is ignored outside IDLE. Operand and mode changes after the accept have no effect.
- Arithmetic: the accumulator is CW bits and is zero-extended from each C-bit popcount. The maximum value is W, so it cannot overflow.
- The distance and similarity results of the same operands always sum to W.
- N=1 (C=W) is legal: BUSY lasts exactly one cycle.
- Reset (rst_n=0 at an edge), from any state including mid-BUSY:
  - state returns to IDLE;
  - the accumulator, k and HB are cleared to 0;
  - the in-flight operation is discarded and no out_valid is produced.
- While rst_n=0: in_ready=0 and out_valid=0.

## Timing
- Accept edge t0. BUSY occupies edges t0+1 … t0+N. out_valid rises after edge t0+N, giving a latency of N cycles.
- Result handshake at edge t1: the state is IDLE after t1, and the earliest next accept is edge t1+1.
- Minimum initiation interval is N+2 cycles.
- in_ready and out_valid are decoded directly from state registers, with no combinational path from any input. Exception: in_ready is also gated by rst_n.
- Reset values: in_ready=0 while in reset and 1 after release; out_valid=0; HB=0.

## Configuration
- HAMMING_ESIK_EN defined:
  - adds input esik[CW-1:0], latched on accept;
  - adds output esik_gecti (1 bit), valid with out_valid, equal to (HB ≥ esik);
  - esik_gecti resets to 0.
- HAMMING_ESIK_EN undefined: neither port exists and the rest of the behaviour is identical.

## Structure
- Package hamming_pkg:
  - state enum {IDLE, BUSY, DONE};
  - mode constants MOD_BENZERLIK=0 and MOD_MESAFE=1.
- Sub-module hamming_parca: combinational popcount of a C-bit vector to a $clog2(C+1)-bit count, instantiated once on the selected chunk.
- An elaboration-time check fails if W%C≠0 or C>W.

## Test plan
All scenarios use W=16, C=4 unless stated.
- A=16'hFFFF, B=16'hFFFF, mode=0 -> HB=16, with out_valid exactly 4 cycles after accept. Same operands with mode=1 -> HB=0.
- A=16'hA5A5, B=16'h5A5A -> mode=0 gives HB=0; mode=1 gives HB=16.
- A=16'h00F0, B=16'h0000 -> mode=0 gives HB=12; mode=1 gives HB=4.
- Back-to-back, with out_ready=1 and in_valid=1 held continuously -> accepts are exactly 6 cycles apart.
- out_ready held 0 for 5 cycles in DONE with in_valid=1 and A/B toggling -> out_valid, HB=12 and in_ready=0 all stay stable. The result is consumed on the first edge with out_ready=1.
- rst_n=0 for one edge during BUSY after chunk 2 -> next cycle in_ready=1, out_valid=0, HB=0. A following operation returns the correct count.
- W=C=8 build -> latency 1 cycle. With HAMMING_ESIK_EN: A=16'h00F0, B=0, mode=0, esik=12 -> esik_gecti=1; esik=13 -> esik_gecti=0.
